// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift schedule, types.
// PC-1 is applied here as a helper function so the top stays free of table plumbing.
package des_pkg;

  typedef logic [27:0] des_half_t;
  typedef logic [47:0] des_subkey_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } des_state_t;

  // Table entries are DES bit numbers, 1 = MSB of the source vector
  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] res;
    logic [5:0]  src;
    res = 56'd0;
    for (int j = 0; j < 56; j++) begin
      src = 6'd63 - PC1_TAB[6'(j)] + 6'd1;
      res[6'(55 - j)] = key[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} state into a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output des_subkey_t sk
);

  logic [5:0] src_s;

  // Table-driven bit gather
  always_comb begin
    sk    = 48'd0;
    src_s = 6'd0;
    for (int j = 0; j < 48; j++) begin
      src_s = 6'd55 - PC2_TAB[6'(j)] + 6'd1;
      sk[6'(47 - j)] = cd[src_s];
    end
  end

endmodule

// File: rtl/kshift.sv
// 28-bit left rotator for a DES key half; shift=0 rotates by 1, shift=1 by 2.
module kshift (
  input  logic [27:0] din,
  input  logic        shift,
  output logic [27:0] dout
);

  assign dout = shift ? {din[25:0], din[27:26]} : {din[26:0], din[27]};

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: loads one key, then hands out the 16 subkeys
// in encrypt or decrypt order over a valid/ready interface.
module des_key_sched
  import des_pkg::*;
#(
  parameter int unsigned NROUNDS = 32'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] sk_data,
  output logic [3:0]  sk_round,
  output logic        sk_valid,
  input  logic        sk_ready
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 32'd1);

  des_state_t  state_r;
  des_half_t   c_r, d_r;
  logic        dec_r;
  logic [3:0]  round_r;

  logic [55:0] pc1_s;
  des_half_t   c_src_s, d_src_s, c_rl_s, d_rl_s, c_rr_s, d_rr_s;
  logic        lshift_s, rshift_s;

  assign pc1_s = pc1(key_in);

  // The rotators see the fresh PC-1 halves while idle (load rotates by 1) and the state while running
  always_comb begin
    if (state_r == RUN) begin
      c_src_s  = c_r;
      d_src_s  = d_r;
      lshift_s = (SHIFT_SCHED[round_r + 4'd1] == 2'd2);
    end else begin
      c_src_s  = pc1_s[55:28];
      d_src_s  = pc1_s[27:0];
      lshift_s = 1'b0;
    end
  end

  kshift u_kshift_c (.din(c_src_s), .shift(lshift_s), .dout(c_rl_s));
  kshift u_kshift_d (.din(d_src_s), .shift(lshift_s), .dout(d_rl_s));

  assign rshift_s = (SHIFT_SCHED[4'd15 - round_r] == 2'd2);
  assign c_rr_s   = rshift_s ? {c_r[1:0], c_r[27:2]} : {c_r[0], c_r[27:1]};
  assign d_rr_s   = rshift_s ? {d_r[1:0], d_r[27:2]} : {d_r[0], d_r[27:1]};

  des_pc2 u_pc2 (.cd({c_r, d_r}), .sk(sk_data));

  assign sk_round = round_r;

  // Sequencer state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      c_r       <= 28'd0;
      d_r       <= 28'd0;
      dec_r     <= 1'b0;
      round_r   <= 4'd0;
      key_ready <= 1'b0;
      sk_valid  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (key_valid && key_ready) begin
            // Decrypt starts from the unrotated halves: 28 net shifts return to PC-1(key)
            if (decrypt) begin
              c_r <= pc1_s[55:28];
              d_r <= pc1_s[27:0];
            end else begin
              c_r <= c_rl_s;
              d_r <= d_rl_s;
            end
            dec_r     <= decrypt;
            round_r   <= 4'd0;
            state_r   <= RUN;
            key_ready <= 1'b0;
            sk_valid  <= 1'b1;
          end else begin
            key_ready <= 1'b1;
            sk_valid  <= 1'b0;
          end
        end
        RUN: begin
          if (sk_ready) begin
            if (round_r == LAST_ROUND) begin
              state_r   <= IDLE;
              round_r   <= 4'd0;
              key_ready <= 1'b1;
              sk_valid  <= 1'b0;
            end else begin
              round_r <= round_r + 4'd1;
              if (dec_r) begin
                c_r <= c_rr_s;
                d_r <= d_rr_s;
              end else begin
                c_r <= c_rl_s;
                d_r <= d_rl_s;
              end
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          key_ready <= 1'b0;
          sk_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the FIPS example key schedule.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = 64'd0;
  logic        decrypt = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [47:0] sk_data;
  logic [3:0]  sk_round;
  logic        sk_valid;
  logic        sk_ready = 1'b1;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR_MASK = 64'h0101010101010101;

  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .decrypt(decrypt),
    .key_valid(key_valid), .key_ready(key_ready), .sk_data(sk_data),
    .sk_round(sk_round), .sk_valid(sk_valid), .sk_ready(sk_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [63:0] key, input logic dec);
    check("key_ready_idle", 64'(key_ready), 64'd1);
    key_in    = key;
    decrypt   = dec;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Walks the subkey stream; each negedge checks the presented subkey, then drives sk_ready
  task automatic stream(input logic dec, input bit rnd, input bit inject, input int stop_at);
    int idx = 0;
    int cyc = 0;
    while (idx < stop_at && cyc < 200) begin
      check("sk_valid_run", 64'(sk_valid), 64'd1);
      check("key_ready_run", 64'(key_ready), 64'd0);
      check("sk_round", 64'(sk_round), 64'(idx));
      check("sk_data", 64'(sk_data), 64'(dec ? ks[15 - idx] : ks[idx]));
      sk_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      key_valid = (inject && idx == 5);
      key_in    = 64'h0E329232EA6D0D73;
      decrypt   = ~dec;
      @(negedge clk);
      if (sk_ready) idx++;
      cyc++;
    end
    key_valid = 1'b0;
    sk_ready  = 1'b1;
    check("handshakes", 64'(idx), 64'(stop_at));
  endtask

  task automatic idle_check();
    check("sk_valid_done", 64'(sk_valid), 64'd0);
    check("key_ready_done", 64'(key_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_key_ready", 64'(key_ready), 64'd0);
    check("rst_sk_valid", 64'(sk_valid), 64'd0);
    check("rst_sk_round", 64'(sk_round), 64'd0);
    check("rst_sk_data", 64'(sk_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Encrypt, full-rate: first subkey one cycle after acceptance, idle 17 cycles after
    load(FIPS_KEY, 1'b0);
    stream(1'b0, 1'b0, 1'b0, 16);
    idle_check();

    // Decrypt order
    load(FIPS_KEY, 1'b1);
    stream(1'b1, 1'b0, 1'b0, 16);
    idle_check();

    // Parity bits must not matter
    load(FIPS_KEY ^ PAR_MASK, 1'b0);
    stream(1'b0, 1'b0, 1'b0, 16);
    idle_check();

    // Random backpressure
    load(FIPS_KEY, 1'b0);
    stream(1'b0, 1'b1, 1'b0, 16);
    idle_check();
    load(FIPS_KEY, 1'b1);
    stream(1'b1, 1'b1, 1'b0, 16);
    idle_check();

    // A key offered mid-stream is ignored
    load(FIPS_KEY, 1'b0);
    stream(1'b0, 1'b0, 1'b1, 16);
    idle_check();

    // Reset while round 7 is presented abandons the stream
    load(FIPS_KEY, 1'b0);
    stream(1'b0, 1'b0, 1'b0, 7);
    check("pre_rst_round", 64'(sk_round), 64'd7);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_sk_valid", 64'(sk_valid), 64'd0);
    check("midrst_sk_round", 64'(sk_round), 64'd0);
    check("midrst_sk_data", 64'(sk_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check();
    load(FIPS_KEY, 1'b1);
    stream(1'b1, 1'b0, 1'b0, 16);
    idle_check();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
